// File: rtl/crossbar_pkg.sv
// Shared types and constants for the four-port byte-stream crossbar.
// Queue entries carry the frame-end flag next to the data byte.
package crossbar_pkg;

   localparam int         NUM_PORTS  = 4;
   localparam logic [2:0] DEST_BCAST = 3'd4;

   typedef logic [2:0] dest_t;
   typedef logic [1:0] port_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } entry_t;

   // Per-TX-port arbitration state: idle, streaming a unicast frame, or part of a broadcast
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_UNI   = 2'd1,
      TX_BCAST = 2'd2
   } tx_state_t;

   // A byte is present when the tag is a real destination other than the sender itself
   function automatic logic byte_valid(input dest_t dest, input port_t own);
      return (dest <= DEST_BCAST) && (dest != {1'b0, own});
   endfunction

endpackage

// File: rtl/crossbar_rx_queue.sv
// Store-and-forward byte queue for one RX port. Frames become visible only once their
// last byte is written; a frame that meets a full queue is rolled back and dropped.
module crossbar_rx_queue
   import crossbar_pkg::*;
#(
   parameter int    P_QUEUE_ADDR_WIDTH = 7,
   parameter port_t P_PORT             = 2'd0
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  dest_t      rx_dest,
   input  logic       pop,
   output logic       head_avail,
   output dest_t      head_dest,
   output entry_t     head_entry
);

   localparam int AW    = P_QUEUE_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;

   typedef logic [AW:0] ptr_t;

   entry_t mem      [DEPTH];
   dest_t  dest_mem [DEPTH];

   ptr_t  wr_ptr, commit_ptr, rd_ptr;
   logic  in_frame, dropping;
   dest_t frame_dest, cur_dest;
   logic  valid, full, wr_en;

   assign valid    = byte_valid(rx_dest, P_PORT);
   assign cur_dest = in_frame ? frame_dest : rx_dest;
   assign full     = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
   assign wr_en    = valid && !dropping && !full;

   // Every byte carries its frame's destination, so the head descriptor is a plain read
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]]      <= entry_t'({rx_done, rx_data});
         dest_mem[wr_ptr[AW-1:0]] <= cur_dest;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         in_frame   <= 1'b0;
         dropping   <= 1'b0;
         frame_dest <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
         if (valid) begin
            if (!in_frame) frame_dest <= rx_dest;
            in_frame <= !rx_done;
            if (dropping) begin
               if (rx_done) dropping <= 1'b0;
            end else if (full) begin
               wr_ptr   <= commit_ptr;
               dropping <= !rx_done;
            end else begin
               wr_ptr <= wr_ptr + ptr_t'(1);
               if (rx_done) commit_ptr <= wr_ptr + ptr_t'(1);
            end
         end
      end
   end

   // Everything between the read and commit pointers belongs to complete frames
   assign head_avail = (rd_ptr != commit_ptr);
   assign head_entry = mem[rd_ptr[AW-1:0]];
   assign head_dest  = dest_mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/switch_crossbar.sv
// Four-port crossbar: per-RX store-and-forward queues, per-TX round-robin arbiters,
// broadcast reservation with a global round-robin pointer, and registered outputs.
module switch_crossbar
   import crossbar_pkg::*;
#(
   parameter int P_QUEUE_ADDR_WIDTH = 7
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic [7:0] rx_data0,
   input  logic [7:0] rx_data1,
   input  logic [7:0] rx_data2,
   input  logic [7:0] rx_data3,
   input  logic       rx_done0,
   input  logic       rx_done1,
   input  logic       rx_done2,
   input  logic       rx_done3,
   input  logic [2:0] rx_dest0,
   input  logic [2:0] rx_dest1,
   input  logic [2:0] rx_dest2,
   input  logic [2:0] rx_dest3,
   output logic [7:0] tx_data0,
   output logic [7:0] tx_data1,
   output logic [7:0] tx_data2,
   output logic [7:0] tx_data3,
   output logic       tx_ctrl0,
   output logic       tx_ctrl1,
   output logic       tx_ctrl2,
   output logic       tx_ctrl3
);

   logic [7:0] rx_data_a [NUM_PORTS];
   logic       rx_done_a [NUM_PORTS];
   dest_t      rx_dest_a [NUM_PORTS];

   assign rx_data_a = '{rx_data0, rx_data1, rx_data2, rx_data3};
   assign rx_done_a = '{rx_done0, rx_done1, rx_done2, rx_done3};
   assign rx_dest_a = '{rx_dest0, rx_dest1, rx_dest2, rx_dest3};

   logic [NUM_PORTS-1:0] head_avail, pop, streaming;
   dest_t                head_dest  [NUM_PORTS];
   entry_t               head_entry [NUM_PORTS];

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_queue
      crossbar_rx_queue #(
         .P_QUEUE_ADDR_WIDTH(P_QUEUE_ADDR_WIDTH),
         .P_PORT            (port_t'(g))
      ) u_queue (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .rx_data   (rx_data_a[g]),
         .rx_done   (rx_done_a[g]),
         .rx_dest   (rx_dest_a[g]),
         .pop       (pop[g]),
         .head_avail(head_avail[g]),
         .head_dest (head_dest[g]),
         .head_entry(head_entry[g])
      );
   end

   tx_state_t            state_q   [NUM_PORTS];
   tx_state_t            state_d   [NUM_PORTS];
   port_t                src_q     [NUM_PORTS];
   port_t                src_d     [NUM_PORTS];
   port_t                uni_ptr_q [NUM_PORTS];
   port_t                uni_ptr_d [NUM_PORTS];
   port_t                bc_ptr_q, bc_ptr_d;
   logic [7:0]           tx_data_q [NUM_PORTS];
   logic [NUM_PORTS-1:0] tx_ctrl_q;
   logic [NUM_PORTS-1:0] bc_req, bc_ready, blocked;

   // A queue is popped whenever any port is granted to it; all granted ports move in lockstep
   always_comb begin
      streaming = '0;
      for (int t = 0; t < NUM_PORTS; t++) begin
         if (state_q[t] != TX_IDLE) streaming[src_q[t]] = 1'b1;
      end
   end
   assign pop = streaming;

   always_comb begin
      port_t cand;
      logic  bc_done, uni_done;
      state_d   = state_q;
      src_d     = src_q;
      uni_ptr_d = uni_ptr_q;
      bc_ptr_d  = bc_ptr_q;
      bc_req    = '0;
      bc_ready  = '0;
      blocked   = '0;
      cand      = '0;
      bc_done   = 1'b0;
      uni_done  = 1'b0;

      for (int t = 0; t < NUM_PORTS; t++) begin
         if (state_q[t] != TX_IDLE && head_entry[src_q[t]].last) state_d[t] = TX_IDLE;
      end

      // A pending head broadcast reserves its three targets against new unicast grants
      for (int s = 0; s < NUM_PORTS; s++) begin
         if (head_avail[s] && !streaming[s] && head_dest[s] == DEST_BCAST) begin
            bc_req[s]   = 1'b1;
            bc_ready[s] = 1'b1;
            for (int t = 0; t < NUM_PORTS; t++) begin
               if (t != s) begin
                  blocked[t] = 1'b1;
                  if (state_q[t] != TX_IDLE) bc_ready[s] = 1'b0;
               end
            end
         end
      end

      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = bc_ptr_q + port_t'(i);
         if (!bc_done && bc_req[cand] && bc_ready[cand]) begin
            bc_done  = 1'b1;
            bc_ptr_d = cand + port_t'(1);
            for (int t = 0; t < NUM_PORTS; t++) begin
               if (port_t'(t) != cand) begin
                  state_d[t] = TX_BCAST;
                  src_d[t]   = cand;
               end
            end
         end
      end

      for (int t = 0; t < NUM_PORTS; t++) begin
         uni_done = 1'b0;
         if (state_q[t] == TX_IDLE && !blocked[t]) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               cand = uni_ptr_q[t] + port_t'(i);
               if (!uni_done && head_avail[cand] && !streaming[cand] &&
                   head_dest[cand] == {1'b0, port_t'(t)}) begin
                  uni_done     = 1'b1;
                  state_d[t]   = TX_UNI;
                  src_d[t]     = cand;
                  uni_ptr_d[t] = cand + port_t'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int t = 0; t < NUM_PORTS; t++) begin
            state_q[t]   <= TX_IDLE;
            src_q[t]     <= '0;
            uni_ptr_q[t] <= '0;
            tx_data_q[t] <= '0;
         end
         tx_ctrl_q <= '0;
         bc_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         uni_ptr_q <= uni_ptr_d;
         bc_ptr_q  <= bc_ptr_d;
         for (int t = 0; t < NUM_PORTS; t++) begin
            tx_ctrl_q[t] <= (state_q[t] != TX_IDLE);
            tx_data_q[t] <= (state_q[t] != TX_IDLE) ? head_entry[src_q[t]].data : 8'h00;
         end
      end
   end

   assign tx_data0 = tx_data_q[0];
   assign tx_data1 = tx_data_q[1];
   assign tx_data2 = tx_data_q[2];
   assign tx_data3 = tx_data_q[3];
   assign tx_ctrl0 = tx_ctrl_q[0];
   assign tx_ctrl1 = tx_ctrl_q[1];
   assign tx_ctrl2 = tx_ctrl_q[2];
   assign tx_ctrl3 = tx_ctrl_q[3];

endmodule

// File: tb/tb_switch_crossbar.sv
// Bench for switch_crossbar: frame-level scoreboard per (source, destination) pair,
// directed scenarios plus randomized concurrent traffic.
module tb_switch_crossbar;

   logic       clk_i  = 1'b0;
   logic       rstn_i = 1'b0;
   logic [7:0] rx_data [4];
   logic       rx_done [4];
   logic [2:0] rx_dest [4];
   logic [7:0] tx_data [4];
   logic       tx_ctrl [4];

   switch_crossbar #(.P_QUEUE_ADDR_WIDTH(7)) dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .rx_data0(rx_data[0]), .rx_data1(rx_data[1]), .rx_data2(rx_data[2]), .rx_data3(rx_data[3]),
      .rx_done0(rx_done[0]), .rx_done1(rx_done[1]), .rx_done2(rx_done[2]), .rx_done3(rx_done[3]),
      .rx_dest0(rx_dest[0]), .rx_dest1(rx_dest[1]), .rx_dest2(rx_dest[2]), .rx_dest3(rx_dest[3]),
      .tx_data0(tx_data[0]), .tx_data1(tx_data[1]), .tx_data2(tx_data[2]), .tx_data3(tx_data[3]),
      .tx_ctrl0(tx_ctrl[0]), .tx_ctrl1(tx_ctrl[1]), .tx_ctrl2(tx_ctrl[2]), .tx_ctrl3(tx_ctrl[3])
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d required finish", cyc);
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
      n_checks++;
      if (obs !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expected);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Expected frames per (src*4 + dst): bytes concatenated, lengths alongside
   logic [7:0] exp_q   [16][$];
   int         exp_len [16][$];
   logic [7:0] cur_q   [4][$];
   int         cur_start [4];
   int         log_src   [4][$];
   int         log_start [4][$];
   int         frames    [4] = '{0, 0, 0, 0};
   bit         abort = 1'b0;

   function automatic int outstanding();
      int n = 0;
      for (int i = 0; i < 16; i++) n += exp_len[i].size();
      return n;
   endfunction

   task automatic flush_expect();
      for (int i = 0; i < 16; i++) begin
         exp_q[i].delete();
         exp_len[i].delete();
      end
   endtask

   task automatic push_expect(input int p, input logic [2:0] dest, input logic [7:0] b[$]);
      for (int t = 0; t < 4; t++) begin
         if ((dest == 3'd4 && t != p) || (dest == 3'(t))) begin
            exp_len[p*4+t].push_back(b.size());
            foreach (b[i]) exp_q[p*4+t].push_back(b[i]);
         end
      end
   endtask

   task automatic match_frame(input int t);
      int hit;
      int len;
      bit same;
      hit = -1;
      len = cur_q[t].size();
      for (int s = 0; s < 4; s++) begin
         if (hit < 0 && exp_len[s*4+t].size() > 0 && exp_len[s*4+t][0] == len) begin
            same = 1'b1;
            for (int i = 0; i < len; i++) if (exp_q[s*4+t][i] != cur_q[t][i]) same = 1'b0;
            if (same) hit = s;
         end
      end
      check_eq($sformatf("frame_tx%0d_len%0d", t, len), 32'(hit >= 0), 32'd1);
      if (hit >= 0) begin
         void'(exp_len[hit*4+t].pop_front());
         for (int i = 0; i < len; i++) void'(exp_q[hit*4+t].pop_front());
      end
      log_src[t].push_back(hit);
      log_start[t].push_back(cur_start[t]);
      frames[t]++;
   endtask

   // Output monitor: a frame is one contiguous run of tx_ctrl
   always @(negedge clk_i) begin
      for (int t = 0; t < 4; t++) begin
         if (!rstn_i) begin
            cur_q[t].delete();
         end else if (tx_ctrl[t]) begin
            if (cur_q[t].size() == 0) cur_start[t] = cyc;
            cur_q[t].push_back(tx_data[t]);
         end else begin
            check_eq("idle_data", 32'(tx_data[t]), 32'd0);
            if (cur_q[t].size() > 0) begin
               match_frame(t);
               cur_q[t].delete();
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_frame(input int p, input logic [2:0] dest, input int len,
                             input logic [7:0] first, input bit rnd, input bit keep,
                             output int last_edge);
      logic [7:0] b[$];
      for (int i = 0; i < len; i++) b.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
      if (keep) push_expect(p, dest, b);
      for (int i = 0; i < len; i++) begin
         if (abort) break;
         rx_data[p] = b[i];
         rx_done[p] = (i == len - 1);
         rx_dest[p] = dest;
         step();
      end
      rx_data[p] = 8'h00;
      rx_done[p] = 1'b0;
      rx_dest[p] = 3'd7;
      last_edge  = cyc;
   endtask

   task automatic rand_frame(input int p);
      int         dummy;
      int         len;
      logic [2:0] d;
      if ($urandom_range(0, 4) == 0) return;
      repeat ($urandom_range(0, 6)) step();
      d   = ($urandom_range(0, 5) == 0) ? 3'd4 : 3'((p + 1 + $urandom_range(0, 2)) % 4);
      len = $urandom_range(8, 64);
      send_frame(p, d, len, 8'h00, 1'b1, 1'b1, dummy);
   endtask

   task automatic send_two(input int p, input logic [7:0] first);
      int dummy;
      send_frame(p, 3'd0, 8, first, 1'b0, 1'b1, dummy);
      send_frame(p, 3'd0, 8, first, 1'b0, 1'b1, dummy);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (outstanding() != 0 && n < 3000) begin
         step();
         n++;
      end
      check_eq({tag, "_drain"}, 32'(outstanding()), 32'd0);
      repeat (4) step();
   endtask

   function automatic int last_start(input int t);
      return (log_start[t].size() > 0) ? log_start[t][log_start[t].size()-1] : -1;
   endfunction

   // ---------------- stimulus ----------------
   int k_edge [4];
   int dst_tab [4]   = '{1, 2, 3, 0};
   logic [7:0] first_tab [4] = '{8'hAA, 8'hCC, 8'hEE, 8'h11};
   int base;
   int snap [4];

   initial begin
      for (int p = 0; p < 4; p++) begin
         rx_data[p] = 8'h00;
         rx_done[p] = 1'b0;
         rx_dest[p] = 3'd7;
      end
      repeat (3) step();
      for (int t = 0; t < 4; t++) begin
         check_eq($sformatf("reset_ctrl%0d", t), 32'(tx_ctrl[t]), 32'd0);
         check_eq($sformatf("reset_data%0d", t), 32'(tx_data[t]), 32'd0);
      end
      @(negedge clk_i) rstn_i = 1'b1;
      step();

      // Disjoint unicast flows, three separated repetitions
      for (int rep = 0; rep < 3; rep++) begin
         fork
            send_frame(0, 3'(dst_tab[0]), 8, first_tab[0], 1'b0, 1'b1, k_edge[0]);
            send_frame(1, 3'(dst_tab[1]), 8, first_tab[1], 1'b0, 1'b1, k_edge[1]);
            send_frame(2, 3'(dst_tab[2]), 8, first_tab[2], 1'b0, 1'b1, k_edge[2]);
            send_frame(3, 3'(dst_tab[3]), 8, first_tab[3], 1'b0, 1'b1, k_edge[3]);
         join
         drain("disjoint");
         for (int p = 0; p < 4; p++)
            check_eq($sformatf("lat_tx%0d", dst_tab[p]), 32'(last_start(dst_tab[p])), 32'(k_edge[p] + 2));
      end
      for (int t = 0; t < 4; t++) check_eq($sformatf("disjoint_frames_tx%0d", t), 32'(frames[t]), 32'd3);

      // Contention on TX0, two frames from each of RX1..RX3
      base = log_src[0].size();
      fork
         send_two(1, 8'hCC);
         send_two(2, 8'hEE);
         send_two(3, 8'h11);
      join
      drain("contend");
      check_eq("contend_frames", 32'(log_src[0].size() - base), 32'd6);
      if (log_src[0].size() - base == 6) begin
         for (int i = 0; i < 6; i++)
            check_eq($sformatf("contend_order%0d", i), 32'(log_src[0][base+i]), 32'((i % 3) + 1));
         for (int i = 1; i < 6; i++)
            check_eq($sformatf("contend_gap%0d", i),
                     32'((log_start[0][base+i] - log_start[0][base+i-1]) >= 9), 32'd1);
      end

      // Broadcast from RX0
      for (int t = 0; t < 4; t++) snap[t] = frames[t];
      send_frame(0, 3'd4, 8, 8'hAA, 1'b0, 1'b1, k_edge[0]);
      drain("bcast");
      check_eq("bcast_tx0_idle", 32'(frames[0] - snap[0]), 32'd0);
      for (int t = 1; t < 4; t++) begin
         check_eq($sformatf("bcast_frames_tx%0d", t), 32'(frames[t] - snap[t]), 32'd1);
         check_eq($sformatf("bcast_start_tx%0d", t), 32'(last_start(t)), 32'(k_edge[0] + 2));
      end

      // Randomized concurrent traffic, drained between rounds
      for (int r = 0; r < 20; r++) begin
         fork
            rand_frame(0);
            rand_frame(1);
            rand_frame(2);
            rand_frame(3);
         join
         drain($sformatf("random%0d", r));
      end

      // Queue-depth boundaries: 128 bytes fit, 129 do not
      snap[0] = frames[0];
      send_frame(3, 3'd0, 128, 8'h00, 1'b0, 1'b1, k_edge[3]);
      drain("depth128");
      check_eq("depth128_frames", 32'(frames[0] - snap[0]), 32'd1);
      send_frame(3, 3'd0, 129, 8'h40, 1'b0, 1'b0, k_edge[3]);
      repeat (20) step();
      check_eq("depth129_dropped", 32'(frames[0] - snap[0]), 32'd1);

      // Overflow: 200-byte frame dropped, following frame intact
      snap[2] = frames[2];
      send_frame(1, 3'd2, 200, 8'h80, 1'b0, 1'b0, k_edge[1]);
      send_frame(1, 3'd2, 8, 8'h5A, 1'b0, 1'b1, k_edge[1]);
      drain("overflow");
      check_eq("overflow_frames", 32'(frames[2] - snap[2]), 32'd1);
      check_eq("overflow_lat", 32'(last_start(2)), 32'(k_edge[1] + 2));

      // Reset in the middle of a TX frame and an RX frame
      fork
         send_frame(0, 3'd1, 16, 8'h20, 1'b0, 1'b1, k_edge[0]);
         send_frame(2, 3'd3, 40, 8'h60, 1'b0, 1'b1, k_edge[2]);
      join_none
      repeat (24) @(posedge clk_i);
      #3;
      check_eq("pre_reset_active", 32'(tx_ctrl[1]), 32'd1);
      for (int t = 0; t < 4; t++) snap[t] = frames[t];
      abort  = 1'b1;
      rstn_i = 1'b0;
      flush_expect();
      #1;
      for (int t = 0; t < 4; t++) check_eq($sformatf("async_rst_ctrl%0d", t), 32'(tx_ctrl[t]), 32'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      abort  = 1'b0;
      rstn_i = 1'b1;
      repeat (60) step();
      for (int t = 0; t < 4; t++)
         check_eq($sformatf("no_stale_tx%0d", t), 32'(frames[t] - snap[t]), 32'd0);
      send_frame(2, 3'd3, 8, 8'h33, 1'b0, 1'b1, k_edge[2]);
      drain("recover");
      check_eq("recover_frames", 32'(frames[3] - snap[3]), 32'd1);
      check_eq("recover_lat", 32'(last_start(3)), 32'(k_edge[2] + 2));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
